// File: rtl/fifo_param_pkg.sv
// Shared FIFO constants and read-mode type. Other environments import
// this package to size their scoreboards against the FIFO defaults.
package fifo_param_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_AF_THRESH  = 14;
    localparam int DEF_AE_THRESH  = 2;
    localparam int DEF_FWFT       = 0;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Number of entries addressed by an ADDR_WIDTH-bit index.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_dp_mem.sv
// FIFO storage: one synchronous write port and one read port whose
// timing depends on the FIFO read mode.
module fifo_dp_mem
    import fifo_param_pkg::*;
#(
    parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:fifo_depth(ADDR_WIDTH)-1];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (MODE == FIFO_STD) begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_q;

            // Registered read: output updates only on an accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end

            assign rdata = rdata_q;
        end else begin : g_async_read
            // Head word is presented continuously; rst/re have no role here.
            logic unused_ctrl;
            assign unused_ctrl = rst ^ re;
            assign rdata       = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with standard or first-word-fall-through
// read mode, occupancy count, threshold flags and sticky error flags.
module param_sync_fifo
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int AE_THRESH  = DEF_AE_THRESH,
    parameter int FWFT       = DEF_FWFT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int         DEPTH = fifo_depth(ADDR_WIDTH);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    generate
        if (ADDR_WIDTH < 1 || AF_THRESH > DEPTH || AE_THRESH >= AF_THRESH) begin : g_param_err
            $error("param_sync_fifo: illegal ADDR_WIDTH/AF_THRESH/AE_THRESH combination");
        end
    endgenerate

    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Status derived straight from the registered pointers.
    assign empty        = (wptr == rptr);
    assign full         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                          (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // Full blocks writes and empty blocks reads, which also resolves the
    // simultaneous read/write cases at the two boundaries.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Pointer advance on accepted operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_dp_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MODE       (MODE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc && !rst),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .re    (rd_acc && !rst),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic rvalid_q;

            // One-cycle valid pulse following each accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                end
            end

            assign rvalid = rvalid_q;
            assign rdata  = mem_rdata;
        end else begin : g_fwft
            // Head is visible whenever data is stored; zero while empty so
            // stale memory never leaks out after reset.
            assign rvalid = !empty;
            assign rdata  = empty ? '0 : mem_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives identical stimulus into a standard-mode and an FWFT-mode FIFO and
// checks both against a queue-based reference model after every clock.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = '0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] rdata_s, rdata_f;
    logic       rvalid_s, rvalid_f;
    logic       full_s, full_f, empty_s, empty_f;
    logic       af_s, af_f, ae_s, ae_f;
    logic [4:0] count_s, count_f;
    logic       ovf_s, ovf_f, udf_s, udf_f;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    int         m_cnt  = 0;
    bit         m_ovf  = 0;
    bit         m_udf  = 0;
    bit         m_rv   = 0;
    logic [7:0] m_last = '0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (4), .AF_THRESH (14), .AE_THRESH (2), .FWFT (0)
    ) dut_std (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wdata (wdata), .rd_en (rd_en),
        .rdata (rdata_s), .rvalid (rvalid_s), .full (full_s), .empty (empty_s),
        .almost_full (af_s), .almost_empty (ae_s), .count (count_s),
        .overflow (ovf_s), .underflow (udf_s), .clr_err (clr_err)
    );

    param_sync_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (4), .AF_THRESH (14), .AE_THRESH (2), .FWFT (1)
    ) dut_fwft (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wdata (wdata), .rd_en (rd_en),
        .rdata (rdata_f), .rvalid (rvalid_f), .full (full_f), .empty (empty_f),
        .almost_full (af_f), .almost_empty (ae_f), .count (count_f),
        .overflow (ovf_f), .underflow (udf_f), .clr_err (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags common to both instances, derived from the model occupancy.
    task automatic chk_status(input string p, input logic [4:0] cnt, input logic fl,
                              input logic em, input logic af, input logic ae,
                              input logic ov, input logic ud);
        chk({p, "count"}, 32'(cnt), 32'(m_cnt));
        chk({p, "full"},  32'(fl),  32'(m_cnt == 16));
        chk({p, "empty"}, 32'(em),  32'(m_cnt == 0));
        chk({p, "almost_full"},  32'(af), 32'(m_cnt >= 14));
        chk({p, "almost_empty"}, 32'(ae), 32'(m_cnt <= 2));
        chk({p, "overflow"},  32'(ov), 32'(m_ovf));
        chk({p, "underflow"}, 32'(ud), 32'(m_udf));
    endtask

    // One clock of stimulus, model update, then checks 1 time unit after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        bit was_full, was_empty, rd_ok, wr_ok;
        @(negedge clk);
        wr_en = w; wdata = d; rd_en = r; clr_err = c; rst = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_cnt = 0; m_ovf = 0; m_udf = 0; m_rv = 0; m_last = '0;
        end else begin
            was_full  = (m_cnt == 16);
            was_empty = (m_cnt == 0);
            rd_ok = r && !was_empty;
            wr_ok = w && !was_full;
            m_rv  = rd_ok;
            if (rd_ok) m_last = q.pop_front();
            if (wr_ok) q.push_back(d);
            m_cnt = q.size();
            if (w && was_full) m_ovf = 1; else if (c) m_ovf = 0;
            if (r && was_empty) m_udf = 1; else if (c) m_udf = 0;
        end
        chk_status("std.", count_s, full_s, empty_s, af_s, ae_s, ovf_s, udf_s);
        chk("std.rvalid", 32'(rvalid_s), 32'(m_rv));
        chk("std.rdata",  32'(rdata_s),  32'(m_last));
        chk_status("fwft.", count_f, full_f, empty_f, af_f, ae_f, ovf_f, udf_f);
        chk("fwft.rvalid", 32'(rvalid_f), 32'(m_cnt != 0));
        if (rs) chk("fwft.rdata_rst", 32'(rdata_f), 32'h0);
        else if (m_cnt != 0) chk("fwft.rdata", 32'(rdata_f), 32'(q[0]));
    endtask

    initial begin
        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);

        // Fill 0x00..0x0F, then an extra write while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        // Full with write+read: only the read goes through
        step(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Ordered fill/drain of 0xA0..0xAF from an empty FIFO
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Write into empty FIFO: FWFT head visible next cycle without rd_en
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Hold occupancy at 8 with 40 simultaneous read/write cycles
        for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom_range(255)), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Underflow: set, hold, clear, set-beats-clear
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        // Empty with write+read: only the write goes through
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Reset at count 10, then fresh traffic
        for (int i = 0; i < 10; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of one data word.
REQ-002 Parameter: ADDR_WIDTH, default 4, log2 of depth (DEPTH = 2**ADDR_WIDTH = 16).
REQ-003 Parameter: AF_THRESH, default 14, almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter: AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH.
REQ-005 Parameter: FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-007 Port: rst  input  1  synchronous, active-high reset.
REQ-008 Port: wr_en  input  1  write request.
REQ-009 Port: wdata  input  DATA_WIDTH  write data.
REQ-010 Port: rd_en  input  1  read request (pop in FWFT mode).
REQ-011 Port: rdata  output  DATA_WIDTH  read data.
REQ-012 Port: rvalid  output  1  rdata is valid.
REQ-013 Port: full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 Port: count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 Port: overflow, underflow  output  1 each  sticky error flags.
REQ-016 Port: clr_err  input  1  clears sticky error flags.

Function
REQ-017 Write is accepted iff wr_en && !full; accepted data is stored at wptr and wptr increments by 1.
REQ-018 Read is accepted iff rd_en && !empty; rptr increments by 1.
REQ-019 Pointers are ADDR_WIDTH+1 bits, wrapping modulo 2*DEPTH; memory is addressed by the low ADDR_WIDTH bits.
REQ-020 empty = (wptr == rptr); full = (MSBs differ && low bits equal); both are registered-pointer derived, with no extra latency.
REQ-021 count = wptr - rptr (modulo 2**(ADDR_WIDTH+1)); updates on the cycle after the accepted operation.
REQ-022 Simultaneous accepted read and write: count is unchanged; both pointers advance.
REQ-023 When full, wr_en && rd_en accepts the read only; the write is dropped and overflow is set.
REQ-024 When empty, wr_en && rd_en accepts the write only; the read is ignored and underflow is set (standard and FWFT modes alike).
REQ-025 overflow is set on any wr_en while full; underflow is set on any rd_en while empty; both hold until clr_err or rst; a set in the same cycle as clr_err wins.
REQ-026 FWFT=0: an accepted read drives rdata = mem[rptr] registered; rvalid pulses high for exactly 1 cycle, 1 cycle after acceptance; rdata holds its value otherwise.
REQ-027 FWFT=1: rdata = mem[rptr[ADDR_WIDTH-1:0]] whenever !empty; rvalid = !empty; rd_en pops the head; data written into an empty FIFO appears on rdata 1 cycle after the write.
REQ-028 almost_full and almost_empty are combinational from count and follow REQ-003/REQ-004.
REQ-029 Elaboration error if ADDR_WIDTH < 1, AF_THRESH > DEPTH, or AE_THRESH >= AF_THRESH.

Reset
REQ-030 rst forces wptr = 0, rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, rvalid = 0, rdata = 0.
REQ-031 rst asserted mid-operation discards all stored entries; requests in the reset cycle are ignored; memory contents are not cleared.

Structure
REQ-032 Shared package fifo_param_pkg holds the default parameter constants and the mode enum (FIFO_STD, FIFO_FWFT); the UVM environment imports it for scoreboard depth checks.
REQ-033 Storage is one sub-module, fifo_dp_mem: one synchronous write port and one read port (registered read for FWFT=0, asynchronous read for FWFT=1).

Verification
REQ-034 Write 16 words 0x00..0x0F with no reads -> full = 1 after the 16th write, almost_full at count 14, count = 16; a 17th write sets overflow and leaves count = 16.
REQ-035 FWFT=0: fill with 0xA0..0xAF, then read 16 -> rdata 0xA0..0xAF in order, each with rvalid 1 cycle after rd_en; empty = 1 at the end.
REQ-036 FWFT=1: write 0x5A into an empty FIFO -> rdata = 0x5A and rvalid = 1 on the next cycle, with no rd_en.
REQ-037 Simultaneous wr_en+rd_en at count 8 for 40 cycles -> count stays 8, data order preserved, pointers wrap twice.
REQ-038 rd_en on an empty FIFO -> underflow = 1 and stays 1; clr_err -> 0 the next cycle; a simultaneous set beats the clear.
REQ-039 rst at count 10 -> next cycle count = 0, empty = 1, all flags at their reset values, and a subsequent write/read returns the new data.
